// File: rtl/l4_parse_sequencer.sv
// L2/L3 header snooper that steers tcp_udp_parser layer selects and counts packet classes.
// Build option: define L4_PARSE_SEQ_QINQ_EN to accept 0x88A8/0x8100 double-tagged frames.
module l4_parse_sequencer #(
  parameter int cnt_w  = 32,
  parameter int wcnt_w = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              parse_en_i,
  input  logic              cnt_clr_i,
  input  logic [63:0]       pkt_data_i,
  input  logic [2:0]        pkt_mod_i,
  input  logic              pkt_sop_i,
  input  logic              pkt_eop_i,
  input  logic              pkt_en_i,
  output logic              tcp_en_o,
  output logic              tcp_udp_ipv4_en_o,
  output logic              tcp_udp_ipv6_en_o,
  output logic              ip_6b_n2b_start_o,
  output logic [cnt_w-1:0]  tcp_cnt_o,
  output logic [cnt_w-1:0]  udp_cnt_o,
  output logic [cnt_w-1:0]  unparsed_cnt_o
);

`ifdef L4_PARSE_SEQ_QINQ_EN
  localparam bit QinqEn = 1'b1;
`else
  localparam bit QinqEn = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_L2, S_L3, S_L4, S_DROP} state_e;

  state_e              state_q, state_d;
  logic [wcnt_w-1:0]   wcnt_q, wcnt_d, cur_idx;
  logic [wcnt_w-1:0]   l4_word_q, l4_word_d;
  logic [1:0]          tags_q, tags_d;
  logic                ipv4_q, ipv4_d, ipv6_q, ipv6_d;
  logic                ip6b_q, ip6b_d, l3_ok_q, l3_ok_d, is_tcp_q, is_tcp_d;
  logic [cnt_w-1:0]    tcp_cnt_q, udp_cnt_q, unp_cnt_q;
  logic                tcp_inc, udp_inc, l2_exit, tag_ok, six_b, frag_ok, l4_hit, in_l4;
  logic [1:0]          unp_inc;
  logic [15:0]         et;
  logic [7:0]          hdr, f0, f1, pr, proto;
  logic [2:0]          base;
  logic [6:0]          l4_sum;
  logic                unused_mod;

  assign unused_mod = ^pkt_mod_i;

  function automatic logic [7:0] get_byte(input logic [63:0] d, input logic [2:0] n);
    return d[8*(7-int'(n)) +: 8];
  endfunction

  assign cur_idx = pkt_sop_i ? '0 : wcnt_q;

  // The L4 word itself must see its enables, so entry is decoded from the live word.
  assign l4_hit = pkt_en_i && !pkt_sop_i && (state_q == S_L3) && l3_ok_q &&
                  (wcnt_q >= l4_word_q);
  assign in_l4  = ((state_q == S_L4) && !(pkt_en_i && pkt_sop_i)) || l4_hit;

  assign tcp_en_o          = in_l4 && is_tcp_q;
  assign tcp_udp_ipv4_en_o = in_l4 && ipv4_q;
  assign tcp_udp_ipv6_en_o = in_l4 && ipv6_q;
  assign ip_6b_n2b_start_o = ip6b_q;
  assign tcp_cnt_o         = tcp_cnt_q;
  assign udp_cnt_o         = udp_cnt_q;
  assign unparsed_cnt_o    = unp_cnt_q;

  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    l4_word_d = l4_word_q;
    tags_d    = tags_q;
    ipv4_d    = ipv4_q;
    ipv6_d    = ipv6_q;
    ip6b_d    = ip6b_q;
    l3_ok_d   = l3_ok_q;
    is_tcp_d  = is_tcp_q;
    tcp_inc   = 1'b0;
    udp_inc   = 1'b0;
    unp_inc   = 2'd0;
    l2_exit   = 1'b0;
    tag_ok    = 1'b1;
    six_b     = 1'b1;
    frag_ok   = 1'b0;
    et        = '0;
    hdr       = '0;
    base      = ip6b_q ? 3'd4 : 3'd0;
    f0        = get_byte(pkt_data_i, base);
    f1        = get_byte(pkt_data_i, base + 3'd1);
    pr        = get_byte(pkt_data_i, base + 3'd3);
    proto     = ipv6_q ? f0 : pr;
    l4_sum    = 7'd14 + {3'b000, tags_q, 2'b00} + (ipv6_q ? 7'd40 : 7'd20);

    if (pkt_en_i) begin
      wcnt_d = (cur_idx == '1) ? cur_idx : cur_idx + 1'b1;
      if (pkt_sop_i) begin
        if (state_q inside {S_L2, S_L3}) unp_inc = unp_inc + 2'd1;
        {tags_d, ipv4_d, ipv6_d, ip6b_d, l3_ok_d, is_tcp_d} = '0;
        l4_word_d = '0;
        if (parse_en_i) begin
          state_d = S_L2;
        end else begin
          state_d = S_DROP;
          unp_inc = unp_inc + 2'd1;
        end
      end else begin
        case (state_q)
          S_L2: begin
            if (cur_idx == wcnt_w'(1)) begin
              et  = {get_byte(pkt_data_i, 3'd4), get_byte(pkt_data_i, 3'd5)};
              hdr = get_byte(pkt_data_i, 3'd6);
              if (et == 16'h8100)                tags_d = 2'd1;
              else if (QinqEn && et == 16'h88A8) tags_d = 2'd2;
              else                               l2_exit = 1'b1;
            end else begin
              l2_exit = 1'b1;
              if (tags_q == 2'd2) begin
                tag_ok = {get_byte(pkt_data_i, 3'd0), get_byte(pkt_data_i, 3'd1)} == 16'h8100;
                et     = {get_byte(pkt_data_i, 3'd4), get_byte(pkt_data_i, 3'd5)};
                hdr    = get_byte(pkt_data_i, 3'd6);
              end else begin
                et     = {get_byte(pkt_data_i, 3'd0), get_byte(pkt_data_i, 3'd1)};
                hdr    = get_byte(pkt_data_i, 3'd2);
                six_b  = 1'b0;
              end
            end
            // IHL sits in the same word as the last EtherType for every tagging depth.
            if (l2_exit) begin
              ip6b_d = six_b;
              if (tag_ok && et == 16'h0800 && hdr[3:0] == 4'd5) begin
                ipv4_d  = 1'b1;
                state_d = S_L3;
              end else if (tag_ok && et == 16'h86DD) begin
                ipv6_d  = 1'b1;
                state_d = S_L3;
              end else begin
                state_d = S_DROP;
                unp_inc = unp_inc + 2'd1;
              end
            end
          end
          S_L3: begin
            if (!l3_ok_q) begin
              frag_ok = ipv6_q || ({f0[4:0], f1} == 13'd0);
              if (frag_ok && (proto == 8'd6 || proto == 8'd17)) begin
                l3_ok_d   = 1'b1;
                is_tcp_d  = (proto == 8'd6);
                l4_word_d = wcnt_w'(l4_sum[6:3]);
              end else begin
                state_d = S_DROP;
                unp_inc = unp_inc + 2'd1;
              end
            end else if (l4_hit) begin
              state_d = S_L4;
              tcp_inc = is_tcp_q;
              udp_inc = !is_tcp_q;
            end
          end
          default: ;
        endcase
      end
      if (pkt_eop_i) begin
        if (state_d inside {S_L2, S_L3}) unp_inc = unp_inc + 2'd1;
        state_d = S_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      l4_word_q <= '0;
      tags_q    <= '0;
      ipv4_q    <= 1'b0;
      ipv6_q    <= 1'b0;
      ip6b_q    <= 1'b0;
      l3_ok_q   <= 1'b0;
      is_tcp_q  <= 1'b0;
      tcp_cnt_q <= '0;
      udp_cnt_q <= '0;
      unp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      l4_word_q <= l4_word_d;
      tags_q    <= tags_d;
      ipv4_q    <= ipv4_d;
      ipv6_q    <= ipv6_d;
      ip6b_q    <= ip6b_d;
      l3_ok_q   <= l3_ok_d;
      is_tcp_q  <= is_tcp_d;
      if (cnt_clr_i) begin
        tcp_cnt_q <= '0;
        udp_cnt_q <= '0;
        unp_cnt_q <= '0;
      end else begin
        tcp_cnt_q <= tcp_cnt_q + cnt_w'(tcp_inc);
        udp_cnt_q <= udp_cnt_q + cnt_w'(udp_inc);
        unp_cnt_q <= unp_cnt_q + cnt_w'(unp_inc);
      end
    end
  end

endmodule

// File: doc/l4_parse_sequencer.md
Name: l4_parse_sequencer

Overview:
- Snoops the 64-bit packet stream that feeds tcp_udp_parser and decodes the L2 and L3 headers.
- Drives the parser's layer-select inputs: tcp_en, tcp_udp_ipv4_en, tcp_udp_ipv6_en, ip_6b_n2b_start.
- Keeps per-class packet counters.
- Enables are presented with zero latency, aligned to each L4 word on the shared stream.

Parameters:
- cnt_w, 32, width of each packet counter.
- wcnt_w, 4, width of the word-index counter; saturates at all-ones.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous assert, active-low
- parse_en_i  in  1  global enable, sampled on the SOP word
- cnt_clr_i  in  1  synchronous clear of all counters
- pkt_data_i  in  64  stream data; byte0 = [63:56]
- pkt_mod_i  in  3  stream mod (unused for decode)
- pkt_sop_i  in  1  start of packet
- pkt_eop_i  in  1  end of packet
- pkt_en_i  in  1  word valid
- tcp_en_o  out  1  to parser tcp_en_i
- tcp_udp_ipv4_en_o  out  1  to parser
- tcp_udp_ipv6_en_o  out  1  to parser
- ip_6b_n2b_start_o  out  1  IP starts at word byte 6 (1) or byte 2 (0)
- tcp_cnt_o  out  cnt_w  TCP packets handed to parser
- udp_cnt_o  out  cnt_w  UDP packets handed to parser
- unparsed_cnt_o  out  cnt_w  packets with no L4 window

Behaviour:
- Reset: all outputs 0; state IDLE; word index 0.
- State changes and word index advance only on cycles with pkt_en_i=1. Idle cycles hold everything.
- The word index is 0 on the SOP word and increments per word, saturating.
- States: IDLE, L2, L3, L4, DROP.
- IDLE: on SOP with parse_en_i=1 go to L2. On SOP with parse_en_i=0 go to DROP.
- L2, EtherType decode:
  - Outer EtherType is bytes 12-13 (word1 bytes 4-5).
  - 0x8100 sets vlan=1; the inner EtherType is bytes 16-17.
  - 0x0800 selects IPv4; 0x86DD selects IPv6; any other value goes to DROP.
- L3, IP start and ip_6b_n2b_start_o:
  - IP start byte: 14 with no tag, 18 with one tag.
  - ip_6b_n2b_start_o = IP start byte mod 8 == 6, registered at L2 exit.
- L3, IPv4 checks (all required):
  - IHL == 5, otherwise DROP.
  - Fragment offset (IP bytes 6-7, low 13 bits) == 0, otherwise DROP.
  - Protocol (IP byte 9) is 6 or 17, otherwise DROP.
- L3, IPv6 check: Next Header (IP byte 6) is 6 or 17, otherwise DROP. Extension headers are not followed.
- L3 exit: latch is_tcp and the L4 word index = floor((IP start + IP header length) / 8). The L3 decision is registered before the L4 word arrives.
- L4 window:
  - When word index >= L4 word index, the state is L4.
  - Enables in L4: tcp_udp_ipv4_en_o = ipv4; tcp_udp_ipv6_en_o = ipv6; tcp_en_o = is_tcp.
  - Enables are combinational from registered state and the word index, so they are valid in the same cycle as the L4 word.
  - Enables are asserted on every L4 word up to and including the EOP word. They are 0 in every other state.
- EOP in any state returns to IDLE. A packet that never reached L4 counts as unparsed, including a runt whose EOP arrives before the L4 word.
- SOP while not in IDLE: abandon the current packet, count it as unparsed, and restart the decode on this word.
- Counters:
  - Each increments once per packet: tcp/udp on entry to L4, unparsed on entry to DROP or on early EOP.
  - Counters wrap modulo 2^cnt_w.
  - cnt_clr_i has priority over a same-cycle increment; the result is 0.
- pkt_mod_i is ignored. Enable outputs are undefined-safe during reset (held 0).

Optional Feature:
- Macro: L4_PARSE_SEQ_QINQ_EN.
- When defined:
  - Outer EtherType 0x88A8 followed by inner 0x8100 is accepted.
  - IP then starts at byte 22 and ip_6b_n2b_start_o = 1.
  - The EtherType used for decode is bytes 20-21.
- When undefined: 0x88A8 goes to DROP.

Test Plan:
- Untagged IPv4/TCP, IHL=5, parse_en_i=1 -> ip_6b_n2b_start_o=1; tcp_en_o and tcp_udp_ipv4_en_o are 1 on word 4 through EOP; tcp_cnt_o=1.
- Single-VLAN IPv6/UDP -> ip_6b_n2b_start_o=0; tcp_udp_ipv6_en_o is 1 from word 7 (byte 58); tcp_en_o stays 0; udp_cnt_o=1.
- IPv4 with IHL=6, then IPv4 with fragment offset 0x0010, then ARP (0x0806) -> no enables asserted; unparsed_cnt_o=3.
- 3-word runt (EOP at word 2), then SOP arriving mid-packet -> unparsed_cnt_o increments by 2; the second packet decodes normally.
- pkt_en_i gaps of 5 idle cycles inside an IPv4/UDP packet -> enables are held during the gaps; the L4 window still starts at word 4; rst_n_i low mid-packet gives all outputs 0 immediately.
- cnt_clr_i pulsed on the same cycle as a TCP L4 entry -> tcp_cnt_o=0 on the next cycle; with L4_PARSE_SEQ_QINQ_EN defined, an 0x88A8/0x8100/IPv4/TCP packet has its L4 window start at word 5.
